// File: rtl/dram_ctrl.sv
// dram_ctrl: data-memory controller behind the MEM stage.
// Byte-lane-masked stores into a synchronous word array, and loads that are
// sign- or zero-extended per op. A two-state read FSM stalls the pipeline
// for the one extra cycle the synchronous read needs.
// Optional feature macro: DRAM_MISALIGN_TRAP_EN (misaligned-access trap).
//
// Handshake: the MEM stage holds a request stable while stall_o is high.
// A load is accepted in IDLE (stall_o=1 that cycle) and its data is valid
// on ram_data_o in the following RD_DONE cycle (stall_o=0). Stores complete
// at the edge ending the cycle they are presented and never stall.
module dram_ctrl #(
  parameter int DEPTH_LOG2 = 12,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32  // word width; the array is fixed at 32 bits
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ram_request_i,
  input  logic                  ram_w_request_i,
  input  logic [3:0]            ram_op_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  debug_state_o  // 0 = IDLE, 1 = RD_DONE
);

  // Shared op encodings (funct3-style for loads, bit 3 marks stores).
  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DONE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_q;
  logic [1:0]              off_q;
  logic [31:0]             rd_word_q;
  logic [31:0]             mem_q [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0]   idx;
  logic [1:0]              off;
  logic                    is_sb, is_sh, is_sw, is_lb, is_lbu, is_lh, is_lhu, is_lw;
  logic                    is_store_op, is_load_op;
  logic                    misalign_raw;
  logic                    trap;
  logic                    do_store, do_load;
  logic [3:0]              byte_en;
  logic [31:0]             wr_data;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             fmt_data;

  // Upper address bits alias modulo the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ram_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2];

  assign idx = ram_addr_i[DEPTH_LOG2+1:2];
  assign off = ram_addr_i[1:0];

  // Op decode, misalignment detection and access qualification.
  always_comb begin
    is_sb  = (ram_op_i == OP_SB);
    is_sh  = (ram_op_i == OP_SH);
    is_sw  = (ram_op_i == OP_SW);
    is_lb  = (ram_op_i == OP_LB);
    is_lbu = (ram_op_i == OP_LBU);
    is_lh  = (ram_op_i == OP_LH);
    is_lhu = (ram_op_i == OP_LHU);
    is_lw  = (ram_op_i == OP_LW);
    is_store_op = is_sb | is_sh | is_sw;
    is_load_op  = is_lb | is_lbu | is_lh | is_lhu | is_lw;
`ifdef DRAM_MISALIGN_TRAP_EN
    misalign_raw = ((is_sh | is_lh | is_lhu) & off[0]) |
                   ((is_sw | is_lw) & (off != 2'b00));
`else
    misalign_raw = 1'b0;
`endif
    trap     = ram_request_i & misalign_raw & ~rst_i;
    do_store = ram_request_i & ram_w_request_i & is_store_op & ~trap & ~rst_i;
    do_load  = (state_q == IDLE) & ram_request_i & ~ram_w_request_i &
               is_load_op & ~trap & ~rst_i;
  end

  assign stall_o       = do_load;
  assign misalign_o    = trap;
  assign debug_state_o = state_q;

  // Store lane enables and lane-replicated write data.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = ram_data_i[31:0];
    if (is_sb) begin
      byte_en = 4'b0001 << off;
      wr_data = {4{ram_data_i[7:0]}};
    end else if (is_sh) begin
      byte_en = off[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{ram_data_i[15:0]}};
    end else if (is_sw) begin
      byte_en = 4'b1111;
    end
  end

  // Word array: masked writes and synchronous read; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (do_load) rd_word_q <= mem_q[idx];
  end

  // FSM state register and latched load op/offset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (do_load) begin
        op_q  <= ram_op_i;
        off_q <= off;
      end
    end
  end

  // Next state: IDLE -> RD_DONE on an accepted load, RD_DONE always returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_load) state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load formatting from the latched op/offset; zero outside RD_DONE.
  always_comb begin
    byte_sel = rd_word_q[8*off_q +: 8];
    half_sel = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    fmt_data = 32'h0;
    case (op_q)
      OP_LB:   fmt_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  fmt_data = {24'h0, byte_sel};
      OP_LH:   fmt_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  fmt_data = {16'h0, half_sel};
      OP_LW:   fmt_data = rd_word_q;
      default: fmt_data = 32'h0;
    endcase
    ram_data_o = (state_q == RD_DONE) ? fmt_data : 32'h0;
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed testbench for dram_ctrl with hand-computed expected values.
// Build with +define+DRAM_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_dram_ctrl;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wreq;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  dram_ctrl #(.DEPTH_LOG2(12), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ram_request_i  (req),
    .ram_w_request_i(wreq),
    .ram_op_i       (op),
    .ram_addr_i     (addr),
    .ram_data_i     (wdata),
    .ram_data_o     (rdata),
    .stall_o        (stall),
    .misalign_o     (misalign),
    .debug_state_o  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req   = 1'b0;
    wreq  = 1'b0;
    op    = OP_LW;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  // Present a store for one cycle; checks it does not stall.
  task automatic do_store(input string tag, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] o);
    req = 1'b1; wreq = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    check({tag, " stall"}, {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Present a load, hold it through RD_DONE, check stall pattern and data.
  task automatic do_load(input string tag, input logic [31:0] a,
                         input logic [3:0] o, input logic [31:0] exp);
    req = 1'b1; wreq = 1'b0; op = o; addr = a;
    @(negedge clk);
    check({tag, " stall1"}, {31'h0, stall}, 32'h1);
    check({tag, " data0"}, rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " stall0"}, {31'h0, stall}, 32'h0);
    check({tag, " data"}, rdata, exp);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    // Reset held for 2 cycles while a load is requested
    rst = 1'b1;
    req = 1'b1; wreq = 1'b0; op = OP_LW; addr = 32'h100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst stall", {31'h0, stall}, 32'h0);
      check("rst data", rdata, 32'h0);
      check("rst state", {31'h0, dbg_state}, 32'h0);
      check("rst misalign", {31'h0, misalign}, 32'h0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;

    do_store("sw100", 32'h100, 32'h80FF7F01, OP_SW);
    do_load("lw100", 32'h100, OP_LW, 32'h80FF7F01);
    do_load("lb100", 32'h100, OP_LB, 32'h00000001);
    do_load("lb103", 32'h103, OP_LB, 32'hFFFFFF80);
    do_load("lbu103", 32'h103, OP_LBU, 32'h00000080);
    do_load("lh102", 32'h102, OP_LH, 32'hFFFF80FF);
    do_load("lhu102", 32'h102, OP_LHU, 32'h000080FF);

    do_store("sb101", 32'h101, 32'h000000AA, OP_SB);
    do_load("lw_after_sb", 32'h100, OP_LW, 32'h80FFAA01);

    do_store("sh102", 32'h102, 32'h1234BEEF, OP_SH);
    do_load("lw_after_sh", 32'h100, OP_LW, 32'hBEEFAA01);

    // Aliasing: 0x4000 maps to word 0 with 4096 words
    do_store("sw4000", 32'h4000, 32'h12345678, OP_SW);
    do_load("lw0_alias", 32'h0, OP_LW, 32'h12345678);

    // Invalid op: no stall, no data
    req = 1'b1; wreq = 1'b0; op = 4'hF; addr = 32'h100;
    @(negedge clk);
    check("badop stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("badop data", rdata, 32'h0);
    check("badop state", {31'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();

`ifdef DRAM_MISALIGN_TRAP_EN
    // Misaligned LW traps: no stall, no data
    req = 1'b1; wreq = 1'b0; op = OP_LW; addr = 32'h102;
    @(negedge clk);
    check("mis_lw misalign", {31'h0, misalign}, 32'h1);
    check("mis_lw stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("mis_lw data", rdata, 32'h0);
    check("mis_lw state", {31'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    // Misaligned SW is suppressed
    req = 1'b1; wreq = 1'b1; op = OP_SW; addr = 32'h101; wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("mis_sw misalign", {31'h0, misalign}, 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    do_load("lw_after_mis_sw", 32'h100, OP_LW, 32'hBEEFAA01);
`else
    // Without the trap the offending bits are ignored
    req = 1'b1; wreq = 1'b0; op = OP_LW; addr = 32'h102;
    @(negedge clk);
    check("mis_lw misalign", {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    do_load("mis_lw", 32'h102, OP_LW, 32'hBEEFAA01);
    do_load("mis_lh", 32'h103, OP_LH, 32'hFFFFBEEF);
`endif

    // Reset during RD_DONE forces IDLE and clears data
    req = 1'b1; wreq = 1'b0; op = OP_LW; addr = 32'h100;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_rd state", {31'h0, dbg_state}, 32'h0);
    check("rst_rd data", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
